// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Compare opcodes shared by the branch decoder and resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    // Decoder default of 3'h7 lands on BU_NONE.
    localparam logic [2:0] BU_BEQ  = 3'd0;
    localparam logic [2:0] BU_BNE  = 3'd1;
    localparam logic [2:0] BU_BLT  = 3'd2;
    localparam logic [2:0] BU_BGE  = 3'd3;
    localparam logic [2:0] BU_BLTU = 3'd4;
    localparam logic [2:0] BU_BGEU = 3'd5;
    localparam logic [2:0] BU_RSVD = 3'd6;
    localparam logic [2:0] BU_NONE = 3'd7;

    function automatic logic bu_is_legal(input logic [2:0] op);
        return (op <= BU_BGEU);
    endfunction

endpackage : branch_resolve_unit_pkg
`default_nettype wire

// File: rtl/branch_resolve_unit_cmp.sv
`default_nettype none
// ============================================================================
// Module      : bu_cmp
// Description : RV32I branch comparator (cmp_op, a, b -> taken).
// Revision    : 1.0 - initial release
// ============================================================================
module bu_cmp
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0]  i_cmp_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_a == i_b);
    assign w_lt  = ($signed(i_a) < $signed(i_b));
    assign w_ltu = (i_a < i_b);

    always_comb begin
        o_taken = 1'b0;
        case (i_cmp_op)
            BU_BEQ:  o_taken = w_eq;
            BU_BNE:  o_taken = !w_eq;
            BU_BLT:  o_taken = w_lt;
            BU_BGE:  o_taken = !w_lt;
            BU_BLTU: o_taken = w_ltu;
            BU_BGEU: o_taken = !w_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule : bu_cmp
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves one conditional branch at a time, redirects fetch and
//               squashes younger instructions; keeps wrap-around statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_cmp_op,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_target,
    output logic             o_redirect_valid,
    input  logic             i_redirect_ready,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush,
    output logic             o_misalign,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_eval     = 2'd1;
    localparam logic [1:0] c_redirect = 2'd2;
    localparam logic [1:0] c_flush    = 2'd3;

    localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_cmp_op;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_pc;
    logic [31:0]      r_target;
    logic [31:0]      r_redirect_pc;
    logic [3:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic w_taken;
    logic w_legal;
    logic w_aligned;
    logic w_accept;
    logic w_resolve;
    logic w_load_redirect;
    logic w_handshake;
    logic w_illegal;
    logic w_misalign;

    // The branch PC is captured with the request but not consumed on the resolve path.
    logic w_unused_pc;
    assign w_unused_pc = ^r_pc;

    bu_cmp u_cmp (
        .i_cmp_op (r_cmp_op),
        .i_a      (r_rs1),
        .i_b      (r_rs2),
        .o_taken  (w_taken)
    );

    assign w_legal         = bu_is_legal(r_cmp_op);
    assign w_aligned       = (r_target[1:0] == 2'b00);
    assign w_accept        = (r_state == c_idle) && i_valid;
    assign w_resolve       = (r_state == c_eval) && w_legal;
    assign w_load_redirect = w_resolve && w_taken && w_aligned;
    assign w_handshake     = (r_state == c_redirect) && i_redirect_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_illegal   = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            c_idle: begin
                if (i_valid) w_state_nxt = c_eval;
            end
            c_eval: begin
                w_state_nxt = c_idle;
                if (!w_legal) begin
                    w_illegal = 1'b1;
                end else if (w_taken && !w_aligned) begin
                    w_misalign = 1'b1;
                end else if (w_taken) begin
                    w_state_nxt = c_redirect;
                end
            end
            c_redirect: begin
                if (i_redirect_ready) begin
                    w_state_nxt = (FLUSH_CYCLES == 0) ? c_idle : c_flush;
                end
            end
            c_flush: begin
                if (r_flush_cnt <= 4'd1) w_state_nxt = c_idle;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_idle;
            r_cmp_op      <= BU_NONE;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_pc          <= '0;
            r_target      <= '0;
            r_redirect_pc <= '0;
            r_flush_cnt   <= '0;
            r_branch_cnt  <= '0;
            r_taken_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cmp_op <= i_cmp_op;
                r_rs1    <= i_rs1;
                r_rs2    <= i_rs2;
                r_pc     <= i_pc;
                r_target <= i_target;
            end
            if (w_resolve) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_load_redirect) r_redirect_pc <= r_target;
            if (w_handshake) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                r_flush_cnt <= c_flush_load;
            end else if (r_state == c_flush) begin
                r_flush_cnt <= r_flush_cnt - 4'd1;
            end
        end
    end

    assign o_ready          = (r_state == c_idle);
    assign o_redirect_valid = (r_state == c_redirect);
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = (r_state == c_flush);
    assign o_misalign       = w_misalign;
    assign o_illegal        = w_illegal;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_taken_cnt      = r_taken_cnt;

endmodule : branch_resolve_unit
`default_nettype wire
